// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_arbiter
// Purpose  : Round-robin arbiter sharing one external iterative multiplier
//            between two requesters, with run timeout and sticky error flag.
// Revision : 1.0  initial release
// ============================================================================
module mul_arbiter #(
    parameter int TMO = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        u0,
    input  logic        u1,
    input  logic [31:0] x0,
    input  logic [31:0] y0,
    input  logic [31:0] x1,
    input  logic [31:0] y1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [63:0] z,
    output logic        busy,
    output logic        err,
    output logic        m_run,
    output logic        m_u,
    output logic [31:0] m_x,
    output logic [31:0] m_y,
    input  logic        m_stall,
    input  logic [63:0] m_z
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [6:0] c_tmo = 7'(TMO);

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic        r_last;
    logic        r_owner;
    logic        r_u;
    logic [31:0] r_x;
    logic [31:0] r_y;
    logic [63:0] r_z;
    logic        r_err;

    logic        w_any;
    logic        w_sel;
    logic        w_timeout;

    assign w_any     = req0 | req1;
    // On a tie the requester not granted last wins; r_last resets to 1 so 0 wins first.
    assign w_sel     = (req0 & req1) ? ~r_last : req1;
    assign w_timeout = m_stall && (({1'b0, r_cnt} + 7'd1) >= c_tmo);

    always_comb begin
        w_next = r_state;
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        done0  = 1'b0;
        done1  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any && !rst) begin
                    w_next = S_RUN;
                    gnt0   = ~w_sel;
                    gnt1   = w_sel;
                end
            end
            S_RUN: begin
                if (!m_stall) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
                done0  = ~r_owner & ~rst;
                done1  = r_owner & ~rst;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_u     <= 1'b0;
            r_x     <= 32'd0;
            r_y     <= 32'd0;
            r_z     <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_last  <= w_sel;
                        r_owner <= w_sel;
                        r_u     <= w_sel ? u1 : u0;
                        r_x     <= w_sel ? x1 : x0;
                        r_y     <= w_sel ? y1 : y0;
                        r_cnt   <= 6'd0;
                    end
                end
                S_RUN: begin
                    if (!m_stall) begin
                        r_z <= m_z;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_run = (r_state == S_RUN);
    assign m_u   = r_u;
    assign m_x   = r_x;
    assign m_y   = r_y;
    assign z     = r_z;
    assign err   = r_err;
    assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_arbiter
// Purpose  : Directed scoreboard bench for mul_arbiter with a 32-cycle stub
//            multiplier that can be forced to stall forever.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_arbiter;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, u0, u1;
    logic [31:0] x0, y0, x1, y1;
    logic        gnt0, gnt1, done0, done1, busy, err;
    logic [63:0] z;
    logic        m_run, m_u, m_stall;
    logic [31:0] m_x, m_y;
    logic [63:0] m_z;

    mul_arbiter #(.TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .u0(u0), .u1(u1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .z(z), .busy(busy), .err(err),
        .m_run(m_run), .m_u(m_u), .m_x(m_x), .m_y(m_y),
        .m_stall(m_stall), .m_z(m_z)
    );

    always #5 clk = ~clk;

    // Stub multiplier: releases stall on its 32nd run cycle unless stuck.
    logic [5:0] mcnt = 6'd0;
    logic       stuck;
    always @(posedge clk) mcnt <= m_run ? mcnt + 6'd1 : 6'd0;
    assign m_stall = stuck | (mcnt != 6'd31);
    always_comb begin
        if (m_u) m_z = {{32{m_x[31]}}, m_x} * {{32{m_y[31]}}, m_y};
        else     m_z = {32'd0, m_x} * {32'd0, m_y};
    end

    typedef struct {
        logic        owner;
        logic [63:0] z;
    } exp_t;
    exp_t sbq[$];

    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    int   g_cyc = 0;
    logic g_who = 1'b0;
    logic g_evt = 1'b0;
    logic d_evt = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, return 1 time unit after the next posedge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        cycle++;
        g_evt = gnt0 | gnt1;
        d_evt = done0 | done1;
        if (g_evt) begin
            chk("gnt_onehot", 64'(gnt0 & gnt1), 64'd0);
            g_who = gnt1;
            g_cyc = cycle;
        end
        if (d_evt) begin
            chk("done_onehot", 64'(done0 & done1), 64'd0);
            tests++;
            assert (sbq.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_done: observed done%0d expected none", done1);
            end
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("done_owner", 64'(done1), 64'(e.owner));
                chk("done_z", z, e.z);
                chk("done_latency", 64'(cycle - g_cyc), 64'd33);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        g_evt = 1'b0;
        while (!g_evt && n < 100) begin
            cyc();
            n++;
        end
        chk("gnt_seen", 64'(g_evt), 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        d_evt = 1'b0;
        while (!d_evt && n < 100) begin
            cyc();
            n++;
        end
        chk("done_seen", 64'(d_evt), 64'd1);
    endtask

    int n;
    int prev;

    initial begin
        rst = 1'b1; stuck = 1'b0;
        req0 = 1'b0; req1 = 1'b0; u0 = 1'b0; u1 = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (2) cyc();
        chk("rst_z", z, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mrun", 64'(m_run), 64'd0);
        chk("rst_mx", 64'(m_x), 64'd0);

        // Unsigned 0xFFFFFFFF * 2 straight out of reset
        req0 = 1'b1; u0 = 1'b0; x0 = 32'hFFFF_FFFF; y0 = 32'd2;
        sbq.push_back('{owner: 1'b0, z: 64'h0000_0001_FFFF_FFFE});
        rst = 1'b0;
        wait_gnt(n);
        chk("t1_gnt_cycle", 64'(n), 64'd1);
        chk("t1_gnt_who", 64'(g_who), 64'd0);
        req0 = 1'b0;
        cyc();
        chk("t1_mrun", 64'(m_run), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done();

        // Signed -3 * 5
        req1 = 1'b1; u1 = 1'b1; x1 = 32'hFFFF_FFFD; y1 = 32'd5;
        sbq.push_back('{owner: 1'b1, z: 64'hFFFF_FFFF_FFFF_FFF1});
        wait_gnt(n);
        chk("t2_gnt_who", 64'(g_who), 64'd1);
        req1 = 1'b0;
        wait_done();

        // Both held after reset: grants alternate 0,1,0,1 every 34 cycles
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req0 = 1'b1; u0 = 1'b0; x0 = 32'd1000;       y0 = 32'd3;
        req1 = 1'b1; u1 = 1'b1; x1 = 32'hFFFF_FFF9; y1 = 32'd9;
        for (int k = 0; k < 4; k++) begin
            sbq.push_back('{owner: k[0], z: k[0] ? 64'hFFFF_FFFF_FFFF_FFC1 : 64'd3000});
        end
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(n);
            chk("t3_gnt_order", 64'(g_who), 64'(k % 2));
            if (k > 0) chk("t3_gnt_spacing", 64'(g_cyc - prev), 64'd34);
            prev = g_cyc;
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_done();

        // Operands changed right after the grant must not matter
        req0 = 1'b1; u0 = 1'b0; x0 = 32'd3; y0 = 32'd4;
        sbq.push_back('{owner: 1'b0, z: 64'd12});
        wait_gnt(n);
        x0 = 32'd0; y0 = 32'd0; req0 = 1'b0;
        wait_done();

        // Reset 10 cycles into RUN aborts without a done
        req0 = 1'b1; x0 = 32'd5; y0 = 32'd5;
        wait_gnt(n);
        req0 = 1'b0;
        repeat (10) cyc();
        chk("t5_mrun_before", 64'(m_run), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5_mrun_after_rst", 64'(m_run), 64'd0);
        chk("t5_z_cleared", z, 64'd0);
        req0 = 1'b1; u0 = 1'b0; x0 = 32'd7; y0 = 32'd6;
        sbq.push_back('{owner: 1'b0, z: 64'd42});
        wait_gnt(n);
        req0 = 1'b0;
        wait_done();

        // Multiplier stuck in stall: timeout after TMO run cycles
        stuck = 1'b1;
        req1 = 1'b1; u1 = 1'b0; x1 = 32'd2; y1 = 32'd2;
        wait_gnt(n);
        req1 = 1'b0;
        n = 0;
        while (!err && n < 200) begin
            cyc();
            n++;
        end
        chk("t6_err_latency", 64'(n), 64'(TMO));
        chk("t6_idle", 64'(busy), 64'd0);
        repeat (20) cyc();
        chk("t6_err_sticky", 64'(err), 64'd1);
        chk("t6_z_unchanged", z, 64'd42);
        stuck = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_err_cleared", 64'(err), 64'd0);

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The module SHALL have parameter TMO, default 40, meaning the RUN-cycle count after which an operation is aborted as hung.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req0, req1  in  1 each  requester N wants a multiply; held high until gntN.
REQ-005 u0, u1  in  1 each  requester N signed (1) / unsigned (0) select.
REQ-006 x0, y0, x1, y1  in  32 each  requester N operands.
REQ-007 gnt0, gnt1  out  1 each  one-cycle pulse: requester N's operands are latched this cycle.
REQ-008 done0, done1  out  1 each  one-cycle pulse: z holds requester N's product.
REQ-009 z  out  64  registered product; holds until the next capture.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 err  out  1  sticky timeout flag.
REQ-012 m_run, m_u  out  1 each  multiplier run and signed controls.
REQ-013 m_x, m_y  out  32 each  multiplier operands, driven from internal latches.
REQ-014 m_stall  in  1  multiplier stall; m_z  in  64  multiplier product, valid when m_run=1 and m_stall=0.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE: with any reqN high, select one requester, latch its u/x/y, pulse its gnt, record the owner and go to RUN; with no request, stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: on a simultaneous request, grant the requester not granted last; after reset, requester 0 wins the first tie.
REQ-018 m_run SHALL equal (state==RUN); m_u, m_x and m_y SHALL come from the latches only, so requester inputs after gnt have no effect.
REQ-019 RUN: on a cycle with m_stall=0, capture m_z into z and go to DONE; otherwise stay in RUN and increment the 6-bit RUN counter.
REQ-020 DONE: m_run=0 so the multiplier state returns to 0; pulse done for the owner; go to IDLE.
REQ-021 Latency SHALL be: gnt at cycle A, m_run high A+1..A+32, capture at A+32, done at A+33, next gnt possible at A+34.
REQ-022 Peak throughput SHALL be one operation per 34 cycles.
REQ-023 If the RUN counter reaches TMO without m_stall=0, the FSM SHALL set err and go to IDLE, with no done pulse and z unchanged.
REQ-024 A reqN still high in the cycle after its gnt SHALL count as a new request, evaluated at the next IDLE.
REQ-025 gnt0/gnt1 SHALL never both be high; done0/done1 SHALL never both be high; each done SHALL follow exactly one gnt to the same requester.
REQ-026 A req arriving during RUN or DONE SHALL wait; none is dropped.

Reset
REQ-027 On rst the module SHALL set: state IDLE, RUN counter 0, round-robin pointer favouring requester 0, z=0, err=0, operand latches 0, all gnt/done pulses 0.
REQ-028 rst during RUN SHALL abort the operation with no done pulse.
REQ-029 m_run SHALL be 0 in the first cycle after rst, so the multiplier state clears before any new grant.

Verification
REQ-030 req0, u0=0, x0=0xFFFFFFFF, y0=2 from reset -> gnt0 at cycle 1, done0 at cycle 34, z=0x00000001_FFFFFFFE.
REQ-031 req1, u1=1, x1=0xFFFFFFFD (-3), y1=5 -> done1 33 cycles after gnt1, z=0xFFFFFFFF_FFFFFFF1.
REQ-032 req0 and req1 held high together after reset -> grant order 0,1,0,1 with gnt spacing of 34 cycles; each z matches its own operands.
REQ-033 rst pulsed 10 cycles into RUN -> no done; m_run low the next cycle; the following op (x=7, y=6, unsigned) gives z=42.
REQ-034 Stub multiplier holding m_stall=1 -> err=1 after TMO RUN cycles; FSM back in IDLE; no done; err stays 1 until rst.
REQ-035 x0/y0 changed to 0 the cycle after gnt0 (original x=3, y=4) -> z=12.
